// File: rtl/bcd_bin_seq_ctrl_pkg.sv
// Shared constants and types for the sequential BCD-to-binary converter.
// Used by bcd_bin_seq_ctrl and bcd_bin_step.
package bcd_bin_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] CORR_TH  = 4'd8;
  localparam logic [DIG_W-1:0] CORR_ADJ = 4'd3;
  localparam logic [DIG_W-1:0] DIG_MAX  = 4'd9;

  function automatic logic digit_bad(logic [DIG_W-1:0] d);
    return d > DIG_MAX;
  endfunction

endpackage

// File: rtl/bcd_bin_seq_ctrl_step.sv
// One reverse double-dabble iteration: shift right by one and
// subtract 3 from every shifted BCD digit that is 8 or above.
module bcd_bin_step
  import bcd_bin_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic [DIG_W*DIGITS-1:0] bcd_in,
  input  logic [BIN_W-1:0]        bin_in,
  output logic [DIG_W*DIGITS-1:0] bcd_out,
  output logic [BIN_W-1:0]        bin_out
);

  logic [DIG_W*DIGITS-1:0] sh;
  logic [DIG_W-1:0]        d;

  always_comb begin
    sh      = bcd_in >> 1;
    bin_out = {bcd_in[0], bin_in[BIN_W-1:1]};
    bcd_out = sh;
    d       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = sh[i*DIG_W +: DIG_W];
      if (d >= CORR_TH)
        bcd_out[i*DIG_W +: DIG_W] = d - CORR_ADJ;
    end
  end

endmodule

// File: rtl/bcd_bin_seq_ctrl.sv
// Sequential BCD-to-binary converter, one iteration per clock.
// Optional invalid-digit check: define BCD_INVALID_CHECK_EN.
module bcd_bin_seq_ctrl
  import bcd_bin_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIG_W*DIGITS-1:0] bcd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err_out
);

  localparam int CNT_W = $clog2(BIN_W) + 1;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DIG_W*DIGITS-1:0] bcd_reg;
  logic [BIN_W-1:0]        bin_reg;
  logic [DIG_W*DIGITS-1:0] bcd_nx;
  logic [BIN_W-1:0]        bin_nx;

  assign in_ready = (state == IDLE) && !en_n && !rst;

  bcd_bin_step #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) u_step (
    .bcd_in (bcd_reg),
    .bin_in (bin_reg),
    .bcd_out(bcd_nx),
    .bin_out(bin_nx)
  );

`ifdef BCD_INVALID_CHECK_EN
  logic err_reg;

  function automatic logic any_bad(logic [DIG_W*DIGITS-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_bad(v[i*DIG_W +: DIG_W])) b = 1'b1;
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
      err_out <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && in_ready)
        err_reg <= any_bad(bcd_in);
      if (state == DONE) begin
        if (!out_valid)
          err_out <= err_reg;
        else if (out_ready)
          err_out <= 1'b0;
      end
    end
  end
`else
  assign err_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      out_valid <= 1'b0;
      bin_out   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            state   <= CONV;
`ifdef BCD_INVALID_CHECK_EN
            if (any_bad(bcd_in)) begin
              bin_reg <= '1;
              state   <= DONE;
            end
`endif
          end
        end
        CONV: begin
          if (!en_n) begin
            bcd_reg <= bcd_nx;
            bin_reg <= bin_nx;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(BIN_W - 1))
              state <= DONE;
          end
        end
        DONE: begin
          // first DONE cycle publishes the result; handshake starts after
          if (!out_valid) begin
            out_valid <= 1'b1;
            bin_out   <= bin_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_bin_seq_ctrl.sv
// Self-checking bench for bcd_bin_seq_ctrl (DIGITS=2, BIN_W=7):
// directed table, reset/stall corners and a random arithmetic-model run.
module tb_bcd_bin_seq_ctrl;

  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic       clk = 0;
  logic       rst;
  logic       en_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bcd_in;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] bin_out;
  logic       err_out;

  int checks   = 0;
  int failures = 0;

  bcd_bin_seq_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_n     (en_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_in   (bcd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .err_out  (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    logic [6:0] exp_bin;
    int         exp_lat;
    int         hold;
    int         st_n;
    logic       pre_rdy;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input logic [7:0] b);
    int v, p;
    logic [7:0] t;
    t = b;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(t[3:0]) * p;
      p *= 10;
      t = t >> 4;
    end
    return v;
  endfunction

  task automatic convert(input logic [7:0] b, input int exp_bin,
                         input int exp_err, input int exp_lat,
                         input int hold, input int st_at,
                         input int st_n, input logic pre_rdy);
    int t;
    bit got;
    @(negedge clk);
    en_n = 0;
    out_ready = pre_rdy;
    in_valid = 1;
    bcd_in = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    bcd_in = 8'($urandom);
    t = 0;
    got = 0;
    while (t < 100) begin
      en_n = (t >= st_at && t < st_at + st_n);
      @(posedge clk);
      #1;
      t++;
      if (out_valid) begin
        got = 1;
        break;
      end
      chk("busy_in_ready", int'(in_ready), 0);
    end
    en_n = 0;
    if (!got) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("latency", t, exp_lat);
    chk("bin_out", int'(bin_out), exp_bin);
    chk("err_out", int'(err_out), exp_err);
    out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_bin", int'(bin_out), exp_bin);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("exit_valid", int'(out_valid), 0);
    chk("exit_in_ready", int'(in_ready), 1);
    chk("exit_err", int'(err_out), 0);
    chk("exit_bin_held", int'(bin_out), exp_bin);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h99, 7'h63, 8, 0, 0, 1'b1};
    vecs[1] = '{8'h00, 7'h00, 8, 0, 0, 1'b1};
    vecs[2] = '{8'h47, 7'h2F, 8, 0, 0, 1'b1};
    vecs[3] = '{8'h25, 7'h19, 8, 5, 0, 1'b0};
    vecs[4] = '{8'h63, 7'h3F, 11, 0, 3, 1'b1};
    vecs[5] = '{8'h12, 7'h0C, 8, 2, 0, 1'b0};

    rst = 1;
    en_n = 0;
    in_valid = 0;
    bcd_in = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_err", int'(err_out), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);
    en_n = 1;
    #1;
    chk("idle_en_n_ready", int'(in_ready), 0);
    en_n = 0;

    foreach (vecs[i])
      convert(vecs[i].bcd, int'(vecs[i].exp_bin), 0, vecs[i].exp_lat,
              vecs[i].hold, 2, vecs[i].st_n, vecs[i].pre_rdy);

    // reset during iteration 4 of a conversion
    @(negedge clk);
    in_valid = 1;
    bcd_in = 8'h87;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_bin", int'(bin_out), 0);
    chk("abort_err", int'(err_out), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_idle_ready", int'(in_ready), 1);
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", int'(out_valid), 0);
    end
    convert(8'h12, 12, 0, 8, 0, 2, 0, 1'b1);

`ifdef BCD_INVALID_CHECK_EN
    convert(8'h3A, 127, 1, 1, 1, 50, 0, 1'b0);
    convert(8'hF4, 127, 1, 1, 0, 50, 0, 1'b1);
`endif

    for (int n = 0; n < 25; n++) begin
      logic [7:0] b;
      int sn, sa, hd;
      b = {4'($urandom_range(9)), 4'($urandom_range(9))};
      sn = $urandom_range(3);
      sa = $urandom_range(BIN_W - sn);
      hd = $urandom_range(3);
      convert(b, model(b), 0, BIN_W + 1 + sn, hd, sa, sn,
              1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
